bg_fill_writer: RTL

Rectangle-fill writer for the 320x240 background/frame block RAM. It drives port A (`wea`/`addra`/`dina`) of the 12-bit RGB image memory, which the pixel-fetch path otherwise only reads. On a `start` pulse it fills a rectangle with a single colour, one pixel per enabled cycle, in row-major order. Writes are gated by `wr_allow`, typically vertical blank from the VGA controller, so fills never tear the visible frame.

---
 rtl/bg_fill_writer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/bg_fill_writer.sv
// -----------------------------------------------------------------------------
// bg_fill_writer
//
// Fills a rectangle of the 320x240 12-bit RGB background RAM with one colour.
// It drives write port A of the memory, one pixel per enabled cycle, in
// row-major order. wr_allow gates progress so that writes can be confined to
// vertical blank.
//
// Optional feature macro: BGW_CLIP_EN
//   defined   : pixels outside the image still take a cycle but are not
//               written (wea = 0).
//   undefined : every issued pixel is written at its computed address; no
//               bound comparators are built.
//
// Parameters
//   IMG_W   image width / row pitch in pixels
//   IMG_H   image height in pixels (used only by the clipping logic)
//   ADDR_W  memory address width
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous reset, active low
//   start     one-cycle fill request, sampled only while idle
//   x0, y0    top-left corner of the rectangle
//   w, h      rectangle size in pixels (0 in either gives an empty fill)
//   color     fill colour {R,G,B}
//   wr_allow  write permission; 0 stalls the writer
//   busy      high while pixels are being issued
//   done      one-cycle completion pulse
//   wea       memory write enable
//   addra     memory address
//   dina      memory write data
// -----------------------------------------------------------------------------
module bg_fill_writer #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [8:0]        x0,
  input  logic [8:0]        y0,
  input  logic [8:0]        w,
  input  logic [8:0]        h,
  input  logic [11:0]       color,
  input  logic              wr_allow,
  output logic              busy,
  output logic              done,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [11:0]       dina
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_reg;
  logic [8:0]        w_reg;
  logic [8:0]        h_reg;
  logic [11:0]       color_reg;
  logic [8:0]        cx_reg;
  logic [8:0]        cy_reg;
  logic [ADDR_W-1:0] row_base_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              wea_reg;
  logic [ADDR_W-1:0] addra_reg;
  logic [11:0]       dina_reg;

  logic [ADDR_W-1:0] start_base;
  logic [ADDR_W-1:0] pix_addr;
  logic              last_col;
  logic              last_row;
  logic              in_bounds;

  // Address of the rectangle's top-left pixel. Multiplying by the constant
  // row pitch reduces to shifts and adds; the result wraps to ADDR_W bits.
  assign start_base = ADDR_W'(32'(y0) * 32'(IMG_W) + 32'(x0));
  assign pix_addr   = row_base_reg + ADDR_W'(cx_reg);

  // w_reg and h_reg are never zero while in RUN, so the -1 cannot underflow.
  assign last_col = (cx_reg == w_reg - 9'd1);
  assign last_row = (cy_reg == h_reg - 9'd1);

`ifdef BGW_CLIP_EN
  logic [8:0] x0_reg;
  logic [8:0] y0_reg;
  logic [9:0] col_abs;
  logic [9:0] row_abs;

  // Absolute coordinates carried at 10 bits so x0+cx cannot wrap back into
  // the image.
  assign col_abs   = {1'b0, x0_reg} + {1'b0, cx_reg};
  assign row_abs   = {1'b0, y0_reg} + {1'b0, cy_reg};
  assign in_bounds = (col_abs < 10'(IMG_W)) && (row_abs < 10'(IMG_H));

  always_ff @(posedge clk) begin
    if (!rst) begin
      x0_reg <= '0;
      y0_reg <= '0;
    end else if (state_reg == S_IDLE && start) begin
      x0_reg <= x0;
      y0_reg <= y0;
    end
  end
`else
  assign in_bounds = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      w_reg        <= '0;
      h_reg        <= '0;
      color_reg    <= '0;
      cx_reg       <= '0;
      cy_reg       <= '0;
      row_base_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      wea_reg      <= 1'b0;
      addra_reg    <= '0;
      dina_reg     <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          wea_reg  <= 1'b0;
          done_reg <= 1'b0;
          if (start) begin
            w_reg        <= w;
            h_reg        <= h;
            color_reg    <= color;
            cx_reg       <= '0;
            cy_reg       <= '0;
            row_base_reg <= start_base;
            if (w == 9'd0 || h == 9'd0) begin
              state_reg <= S_DONE;
            end else begin
              state_reg <= S_RUN;
              busy_reg  <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (wr_allow) begin
            addra_reg <= pix_addr;
            dina_reg  <= color_reg;
            wea_reg   <= in_bounds;
            if (last_col) begin
              cx_reg       <= '0;
              row_base_reg <= row_base_reg + ADDR_W'(IMG_W);
              if (last_row) begin
                // done rises together with the final write.
                state_reg <= S_DONE;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
              end else begin
                cy_reg <= cy_reg + 9'd1;
              end
            end else begin
              cx_reg <= cx_reg + 9'd1;
            end
          end else begin
            wea_reg <= 1'b0;
          end
        end

        S_DONE: begin
          // A fill that ran arrives here with done already raised; an empty
          // fill arrives with done low and raises it one cycle later. Either
          // way done is high for exactly one cycle before returning to idle.
          if (done_reg) begin
            state_reg <= S_IDLE;
            done_reg  <= 1'b0;
            wea_reg   <= 1'b0;
            addra_reg <= '0;
            dina_reg  <= '0;
          end else begin
            done_reg <= 1'b1;
          end
        end

        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          wea_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_reg;
  assign done  = done_reg;
  assign wea   = wea_reg;
  assign addra = addra_reg;
  assign dina  = dina_reg;

endmodule
